trap_arbiter: RTL and testbench

- Sequences trap entry for the M-mode-only CPU.
- Arbitrates level interrupt sources (external, software, timer) and synchronous exceptions (illegal op, ecall) into a single trap request, with the priority, cause code and timing the CSR block consumes.
- Stalls the pipeline until it reaches a safe PC-state boundary, then pulses trap_fire exactly once.
- Masks further interrupts until mret.
- Sits between the interrupt sources/EX stage and the CSR/PC-select logic.

---
 rtl/trap_arbiter_if.sv | 34 +++
 rtl/trap_arbiter.sv | 156 +++++++++++++++
 tb/tb_trap_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/trap_arbiter_if.sv
// rtl/trap_arbiter_if.sv - interrupt/exception sources in, trap request to CSR/PC-select out
interface trap_arbiter_if;
    logic       ext_irq;
    logic       sw_irq;
    logic       timer_irq;
    logic       csr_mstatus_mie;
    logic       csr_meie;
    logic       csr_msie;
    logic       csr_mtie;
    logic       exc_req;
    logic [5:0] exc_code;
    logic       cmd_mret;
    logic       cpu_stat_pc;
    logic       stall_req;
    logic       trap_fire;
    logic       trap_is_irq;
    logic [5:0] trap_code;
    logic       in_handler;
    logic [2:0] irq_pend;

    modport slave (
        input  ext_irq, sw_irq, timer_irq,
        input  csr_mstatus_mie, csr_meie, csr_msie, csr_mtie,
        input  exc_req, exc_code, cmd_mret, cpu_stat_pc,
        output stall_req, trap_fire, trap_is_irq, trap_code, in_handler, irq_pend
    );

    modport master (
        output ext_irq, sw_irq, timer_irq,
        output csr_mstatus_mie, csr_meie, csr_msie, csr_mtie,
        output exc_req, exc_code, cmd_mret, cpu_stat_pc,
        input  stall_req, trap_fire, trap_is_irq, trap_code, in_handler, irq_pend
    );
endinterface

// File: rtl/trap_arbiter.sv
// rtl/trap_arbiter.sv - M-mode trap entry sequencer; TRAP_ARB_IRQ_SYNC_EN adds a 2-flop ext_irq synchronizer
module trap_arbiter #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic           clk,
    input  logic           rst,
    trap_arbiter_if.slave  bus
);

    localparam logic [3:0] CNT_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [5:0] CODE_EXT = 6'd11;
    localparam logic [5:0] CODE_SW  = 6'd3;
    localparam logic [5:0] CODE_TIM = 6'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_FIRE,
        S_HANDLER
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_drain_cnt, w_drain_cnt_nxt;
    logic       r_stall_req, w_stall_req_nxt;
    logic       r_trap_fire, w_trap_fire_nxt;
    logic       r_trap_is_irq, w_trap_is_irq_nxt;
    logic [5:0] r_trap_code, w_trap_code_nxt;
    logic       r_in_handler, w_in_handler_nxt;

    logic       w_ext_irq;
    logic       w_e_ext, w_e_sw, w_e_tim, w_any_irq;
    logic [5:0] w_irq_code;

`ifdef TRAP_ARB_IRQ_SYNC_EN
    logic r_ext_sync1, r_ext_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext_sync1 <= 1'b0;
            r_ext_sync2 <= 1'b0;
        end else begin
            r_ext_sync1 <= bus.ext_irq;
            r_ext_sync2 <= r_ext_sync1;
        end
    end

    assign w_ext_irq = r_ext_sync2;
`else
    assign w_ext_irq = bus.ext_irq;
`endif

    assign w_e_ext   = w_ext_irq & bus.csr_meie;
    assign w_e_sw    = bus.sw_irq & bus.csr_msie;
    assign w_e_tim   = bus.timer_irq & bus.csr_mtie;
    assign w_any_irq = (w_e_ext | w_e_sw | w_e_tim) & bus.csr_mstatus_mie;
    assign w_irq_code = w_e_ext ? CODE_EXT : (w_e_sw ? CODE_SW : CODE_TIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_drain_cnt   <= 4'd0;
            r_stall_req   <= 1'b0;
            r_trap_fire   <= 1'b0;
            r_trap_is_irq <= 1'b0;
            r_trap_code   <= 6'd0;
            r_in_handler  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_drain_cnt   <= w_drain_cnt_nxt;
            r_stall_req   <= w_stall_req_nxt;
            r_trap_fire   <= w_trap_fire_nxt;
            r_trap_is_irq <= w_trap_is_irq_nxt;
            r_trap_code   <= w_trap_code_nxt;
            r_in_handler  <= w_in_handler_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_drain_cnt_nxt   = r_drain_cnt;
        w_stall_req_nxt   = 1'b0;
        w_trap_fire_nxt   = 1'b0;
        w_trap_is_irq_nxt = r_trap_is_irq;
        w_trap_code_nxt   = r_trap_code;
        w_in_handler_nxt  = r_in_handler;

        case (r_state)
            S_IDLE: begin
                if (bus.exc_req) begin
                    w_state_nxt       = S_FIRE;
                    w_trap_code_nxt   = bus.exc_code;
                    w_trap_is_irq_nxt = 1'b0;
                    w_stall_req_nxt   = 1'b1;
                    w_trap_fire_nxt   = 1'b1;
                end else if (w_any_irq) begin
                    w_state_nxt       = S_DRAIN;
                    w_trap_code_nxt   = w_irq_code;
                    w_trap_is_irq_nxt = 1'b1;
                    w_stall_req_nxt   = 1'b1;
                    w_drain_cnt_nxt   = 4'd0;
                end
            end

            S_DRAIN: begin
                w_stall_req_nxt = 1'b1;
                if (bus.exc_req) begin
                    w_state_nxt       = S_FIRE;
                    w_trap_code_nxt   = bus.exc_code;
                    w_trap_is_irq_nxt = 1'b0;
                    w_trap_fire_nxt   = 1'b1;
                end else if (!w_any_irq) begin
                    // Source went away before the boundary: drop the stall, never fire.
                    w_state_nxt     = S_IDLE;
                    w_stall_req_nxt = 1'b0;
                end else begin
                    w_trap_code_nxt   = w_irq_code;
                    w_trap_is_irq_nxt = 1'b1;
                    if ((r_drain_cnt == CNT_LAST) && bus.cpu_stat_pc) begin
                        w_state_nxt     = S_FIRE;
                        w_trap_fire_nxt = 1'b1;
                    end else if (r_drain_cnt != CNT_LAST) begin
                        w_drain_cnt_nxt = r_drain_cnt + 4'd1;
                    end
                end
            end

            S_FIRE: begin
                w_state_nxt      = S_HANDLER;
                w_in_handler_nxt = 1'b1;
            end

            S_HANDLER: begin
                if (bus.exc_req) begin
                    w_state_nxt       = S_FIRE;
                    w_trap_code_nxt   = bus.exc_code;
                    w_trap_is_irq_nxt = 1'b0;
                    w_stall_req_nxt   = 1'b1;
                    w_trap_fire_nxt   = 1'b1;
                end else if (bus.cmd_mret) begin
                    w_state_nxt      = S_IDLE;
                    w_in_handler_nxt = 1'b0;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.stall_req   = r_stall_req;
    assign bus.trap_fire   = r_trap_fire;
    assign bus.trap_is_irq = r_trap_is_irq;
    assign bus.trap_code   = r_trap_code;
    assign bus.in_handler  = r_in_handler;
    assign bus.irq_pend    = {w_ext_irq, bus.timer_irq, bus.sw_irq};

endmodule

// File: tb/tb_trap_arbiter.sv
// tb/tb_trap_arbiter.sv - directed vector bench for trap_arbiter (DRAIN_CYCLES = 3)
module tb_trap_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    trap_arbiter_if bus();

    trap_arbiter #(.DRAIN_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // irq is {ext, timer, sw}; en is {mstatus_mie, meie, msie, mtie}
    typedef struct {
        logic       rst;
        logic [2:0] irq;
        logic [3:0] en;
        logic       exc;
        logic [5:0] exc_code;
        logic       mret;
        logic       pc;
        logic       e_stall;
        logic       e_fire;
        logic       e_isirq;
        logic [5:0] e_code;
        logic       e_inh;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [2:0] irq, input logic [3:0] en,
                       input logic exc, input logic [5:0] ec, input logic mret, input logic pc,
                       input logic st, input logic fi, input logic ii, input logic [5:0] co,
                       input logic ih);
        vec_t v;
        v.rst = r; v.irq = irq; v.en = en; v.exc = exc; v.exc_code = ec;
        v.mret = mret; v.pc = pc; v.e_stall = st; v.e_fire = fi; v.e_isirq = ii;
        v.e_code = co; v.e_inh = ih;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] irq, input logic [3:0] en,
                         input logic exc, input logic [5:0] ec, input logic mret, input logic pc);
        rst                 = r;
        bus.ext_irq         = irq[2];
        bus.timer_irq       = irq[1];
        bus.sw_irq          = irq[0];
        bus.csr_mstatus_mie = en[3];
        bus.csr_meie        = en[2];
        bus.csr_msie        = en[1];
        bus.csr_mtie        = en[0];
        bus.exc_req         = exc;
        bus.exc_code        = ec;
        bus.cmd_mret        = mret;
        bus.cpu_stat_pc     = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [3:0] EN = 4'b1111;

    initial begin
        int lat;
        drive(1'b1, 3'b000, 4'b0000, 1'b0, 6'd0, 1'b0, 1'b0);

        // rst irq   en       exc code  mret pc   stall fire isirq code inh
        add(1, 3'b000, EN,      0, 6'd0,  0, 1,   0, 0, 0, 6'd0,  0);
        add(0, 3'b000, EN,      0, 6'd0,  0, 1,   0, 0, 0, 6'd0,  0);
        add(0, 3'b100, EN,      0, 6'd0,  0, 1,   1, 0, 1, 6'd11, 0);
        add(0, 3'b100, EN,      0, 6'd0,  0, 1,   1, 0, 1, 6'd11, 0);
        add(0, 3'b100, EN,      0, 6'd0,  0, 1,   1, 0, 1, 6'd11, 0);
        add(0, 3'b100, EN,      0, 6'd0,  0, 1,   1, 1, 1, 6'd11, 0);
        add(0, 3'b100, EN,      0, 6'd0,  0, 1,   0, 0, 1, 6'd11, 1);
        add(0, 3'b100, EN,      0, 6'd0,  0, 1,   0, 0, 1, 6'd11, 1);
        add(0, 3'b100, EN,      0, 6'd0,  1, 1,   0, 0, 1, 6'd11, 0);
        add(0, 3'b100, EN,      0, 6'd0,  0, 1,   1, 0, 1, 6'd11, 0);
        add(0, 3'b100, EN,      0, 6'd0,  0, 1,   1, 0, 1, 6'd11, 0);
        add(0, 3'b100, EN,      0, 6'd0,  0, 1,   1, 0, 1, 6'd11, 0);
        add(0, 3'b100, EN,      0, 6'd0,  0, 1,   1, 1, 1, 6'd11, 0);
        add(0, 3'b000, EN,      0, 6'd0,  0, 1,   0, 0, 1, 6'd11, 1);
        add(0, 3'b000, EN,      1, 6'd2,  1, 1,   1, 1, 0, 6'd2,  1);
        add(0, 3'b000, EN,      0, 6'd0,  0, 1,   0, 0, 0, 6'd2,  1);
        add(0, 3'b000, EN,      0, 6'd0,  1, 1,   0, 0, 0, 6'd2,  0);
        add(0, 3'b011, EN,      0, 6'd0,  0, 1,   1, 0, 1, 6'd3,  0);
        add(0, 3'b011, EN,      0, 6'd0,  0, 1,   1, 0, 1, 6'd3,  0);
        add(0, 3'b111, EN,      0, 6'd0,  0, 1,   1, 0, 1, 6'd11, 0);
        add(0, 3'b111, EN,      0, 6'd0,  0, 1,   1, 1, 1, 6'd11, 0);
        add(0, 3'b000, EN,      0, 6'd0,  0, 1,   0, 0, 1, 6'd11, 1);
        add(0, 3'b000, EN,      0, 6'd0,  1, 1,   0, 0, 1, 6'd11, 0);
        add(0, 3'b000, EN,      1, 6'd2,  0, 1,   1, 1, 0, 6'd2,  0);
        add(0, 3'b000, EN,      0, 6'd0,  0, 1,   0, 0, 0, 6'd2,  1);
        add(0, 3'b000, EN,      0, 6'd0,  1, 1,   0, 0, 0, 6'd2,  0);
        add(0, 3'b010, EN,      0, 6'd0,  0, 1,   1, 0, 1, 6'd7,  0);
        add(0, 3'b010, EN,      1, 6'd11, 0, 1,   1, 1, 0, 6'd11, 0);
        add(0, 3'b000, EN,      0, 6'd0,  0, 1,   0, 0, 0, 6'd11, 1);
        add(0, 3'b000, EN,      0, 6'd0,  1, 1,   0, 0, 0, 6'd11, 0);
        add(0, 3'b010, EN,      0, 6'd0,  0, 1,   1, 0, 1, 6'd7,  0);
        add(0, 3'b010, EN,      0, 6'd0,  0, 1,   1, 0, 1, 6'd7,  0);
        add(0, 3'b000, EN,      0, 6'd0,  0, 1,   0, 0, 1, 6'd7,  0);
        add(0, 3'b000, EN,      0, 6'd0,  0, 1,   0, 0, 1, 6'd7,  0);
        add(0, 3'b010, 4'b0111, 0, 6'd0,  0, 1,   0, 0, 1, 6'd7,  0);
        add(0, 3'b100, 4'b1011, 0, 6'd0,  0, 1,   0, 0, 1, 6'd7,  0);
        add(0, 3'b000, EN,      0, 6'd0,  0, 1,   0, 0, 1, 6'd7,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].irq, vecs[i].en, vecs[i].exc, vecs[i].exc_code,
                  vecs[i].mret, vecs[i].pc);
            step();
            chk($sformatf("v%0d stall_req", i), 32'(bus.stall_req), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d trap_fire", i), 32'(bus.trap_fire), 32'(vecs[i].e_fire));
            chk($sformatf("v%0d trap_is_irq", i), 32'(bus.trap_is_irq), 32'(vecs[i].e_isirq));
            chk($sformatf("v%0d trap_code", i), 32'(bus.trap_code), 32'(vecs[i].e_code));
            chk($sformatf("v%0d in_handler", i), 32'(bus.in_handler), 32'(vecs[i].e_inh));
            chk($sformatf("v%0d irq_pend", i), 32'(bus.irq_pend), 32'(vecs[i].irq));
        end

        // Boundary held off for 12 cycles: counter saturates, fire waits for cpu_stat_pc.
        drive(1'b0, 3'b010, EN, 1'b0, 6'd0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("pc_hold%0d trap_fire", i), 32'(bus.trap_fire), 32'd0);
            chk($sformatf("pc_hold%0d stall_req", i), 32'(bus.stall_req), 32'd1);
        end
        bus.cpu_stat_pc = 1'b1;
        step();
        chk("pc_rise trap_fire", 32'(bus.trap_fire), 32'd1);
        chk("pc_rise trap_code", 32'(bus.trap_code), 32'd7);
        bus.timer_irq = 1'b0;
        step();
        chk("pc_rise single_fire", 32'(bus.trap_fire), 32'd0);
        chk("pc_rise in_handler", 32'(bus.in_handler), 32'd1);
        bus.cmd_mret = 1'b1;
        step();
        bus.cmd_mret = 1'b0;

        // Reset in the middle of DRAIN.
        bus.ext_irq = 1'b1;
        step();
        step();
        chk("rst_mid stall_before", 32'(bus.stall_req), 32'd1);
        rst = 1'b1;
        bus.ext_irq = 1'b0;
        step();
        chk("rst_mid stall_req", 32'(bus.stall_req), 32'd0);
        chk("rst_mid trap_fire", 32'(bus.trap_fire), 32'd0);
        chk("rst_mid trap_is_irq", 32'(bus.trap_is_irq), 32'd0);
        chk("rst_mid trap_code", 32'(bus.trap_code), 32'd0);
        chk("rst_mid in_handler", 32'(bus.in_handler), 32'd0);
        rst = 1'b0;
        step();
        step();
        chk("rst_mid no_late_fire", 32'(bus.trap_fire), 32'd0);

        // ext_irq to stall_req latency, bounded wait.
        bus.ext_irq = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            step();
            if (bus.stall_req) lat = i;
        end
`ifdef TRAP_ARB_IRQ_SYNC_EN
        chk("ext_to_stall latency", 32'(lat), 32'd3);
`else
        chk("ext_to_stall latency", 32'(lat), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
